// File: rtl/haar_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : haar_window_feeder
// Brief    : Avalon-MM master that loads one Haar window into the classifier
//            slave and polls it for the classification result.
// Revision : 1.0 - initial release
// ============================================================================
module haar_window_feeder #(
    parameter int         WINDOW_SIZE      = 21,
    parameter int         POLL_DELAY       = 3,
    parameter int         POLL_TIMEOUT     = 4095,
    parameter int         FLAG_READY_BIT   = 31,
    parameter int         FLAG_RESULT_BIT  = 30,
    parameter int         FLAG_NEW_COL_BIT = 0,
    parameter logic [3:0] FLAGS_ADDR       = 4'h0,
    parameter logic [3:0] VAR_ADDR         = 4'h1,
    parameter logic [3:0] II_ADDR          = 4'h2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_base_addr_i,
    input  logic        cmd_new_col_i,
    input  logic [31:0] cmd_var_factor_i,
    output logic [31:0] mem_address_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_waitrequest_i,
    input  logic        mem_readdatavalid_i,
    output logic [3:0]  avm_address_o,
    output logic [31:0] avm_writedata_o,
    output logic        avm_write_o,
    output logic        avm_read_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_waitrequest_i,
    output logic        done_o,
    output logic        result_o,
    output logic        error_o,
    output logic        busy_o
);

    localparam int c_WORDS_FULL = WINDOW_SIZE * WINDOW_SIZE;
    localparam int c_IDX_W      = $clog2(c_WORDS_FULL + 1);
    localparam int c_DLY_W      = $clog2(POLL_DELAY + 2);
    localparam int c_POLL_W     = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_VAR, S_WR_FLAGS, S_RD_REQ, S_RD_WAIT,
        S_WR_II, S_POLL_DLY, S_POLL_RD, S_DONE
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  r_words;
    logic [c_DLY_W-1:0]  r_dly_cnt;
    logic [c_POLL_W-1:0] r_poll_cnt;
    logic [31:0]         r_base;
    logic                r_new_col;

    logic [c_IDX_W-1:0]  w_idx_next;
    logic [c_POLL_W-1:0] w_poll_next;
    logic                w_unused_readdata;

    assign w_idx_next        = r_idx + 1'b1;
    assign w_poll_next       = r_poll_cnt + 1'b1;
    assign w_unused_readdata = ^avm_readdata_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_words         <= '0;
            r_dly_cnt       <= '0;
            r_poll_cnt      <= '0;
            r_base          <= '0;
            r_new_col       <= 1'b0;
            cmd_ready_o     <= 1'b1;
            mem_address_o   <= '0;
            mem_read_o      <= 1'b0;
            avm_address_o   <= '0;
            avm_writedata_o <= '0;
            avm_write_o     <= 1'b0;
            avm_read_o      <= 1'b0;
            done_o          <= 1'b0;
            result_o        <= 1'b0;
            error_o         <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_base          <= cmd_base_addr_i;
                        r_new_col       <= cmd_new_col_i;
                        r_words         <= cmd_new_col_i ? c_IDX_W'(c_WORDS_FULL)
                                                         : c_IDX_W'(WINDOW_SIZE);
                        r_idx           <= '0;
                        result_o        <= 1'b0;
                        error_o         <= 1'b0;
                        cmd_ready_o     <= 1'b0;
                        busy_o          <= 1'b1;
                        avm_address_o   <= VAR_ADDR;
                        avm_writedata_o <= cmd_var_factor_i;
                        avm_write_o     <= 1'b1;
                        r_state         <= S_WR_VAR;
                    end
                end
                S_WR_VAR: begin
                    if (!avm_waitrequest_i) begin
                        avm_address_o   <= FLAGS_ADDR;
                        avm_writedata_o <= 32'(r_new_col) << FLAG_NEW_COL_BIT;
                        r_state         <= S_WR_FLAGS;
                    end
                end
                S_WR_FLAGS: begin
                    if (!avm_waitrequest_i) begin
                        avm_write_o   <= 1'b0;
                        mem_read_o    <= 1'b1;
                        mem_address_o <= r_base;
                        r_state       <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!mem_waitrequest_i) begin
                        mem_read_o <= 1'b0;
                        r_state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_readdatavalid_i) begin
                        avm_address_o   <= II_ADDR;
                        avm_writedata_o <= mem_readdata_i;
                        avm_write_o     <= 1'b1;
                        r_state         <= S_WR_II;
                    end
                end
                S_WR_II: begin
                    if (!avm_waitrequest_i) begin
                        avm_write_o <= 1'b0;
                        r_idx       <= w_idx_next;
                        if (w_idx_next == r_words) begin
                            r_dly_cnt <= '0;
                            r_state   <= S_POLL_DLY;
                        end else begin
                            // Address advances by one word and wraps modulo 2^32
                            mem_read_o    <= 1'b1;
                            mem_address_o <= mem_address_o + 32'd4;
                            r_state       <= S_RD_REQ;
                        end
                    end
                end
                S_POLL_DLY: begin
                    // Gives the slave time to drop READY before the first poll
                    if (int'(r_dly_cnt) + 1 >= POLL_DELAY) begin
                        avm_address_o <= FLAGS_ADDR;
                        avm_read_o    <= 1'b1;
                        r_poll_cnt    <= '0;
                        r_state       <= S_POLL_RD;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                S_POLL_RD: begin
                    if (!avm_waitrequest_i) begin
                        if (avm_readdata_i[FLAG_READY_BIT]) begin
                            result_o   <= avm_readdata_i[FLAG_RESULT_BIT];
                            error_o    <= 1'b0;
                            avm_read_o <= 1'b0;
                            done_o     <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (int'(w_poll_next) >= POLL_TIMEOUT) begin
                            result_o   <= 1'b0;
                            error_o    <= 1'b1;
                            avm_read_o <= 1'b0;
                            done_o     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_poll_cnt <= w_poll_next;
                        end
                    end
                end
                S_DONE: begin
                    busy_o      <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_haar_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_haar_window_feeder
// Brief    : Scoreboard bench with memory and Haar-slave responders.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_haar_window_feeder;

    localparam int         WS     = 21;
    localparam int         PT     = 8;
    localparam int         PD     = 3;
    localparam logic [3:0] A_FLAG = 4'h0;
    localparam logic [3:0] A_VAR  = 4'h1;
    localparam logic [3:0] A_II   = 4'h2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_base_addr_i = '0;
    logic        cmd_new_col_i = 1'b0;
    logic [31:0] cmd_var_factor_i = '0;
    logic [31:0] mem_address_o;
    logic        mem_read_o;
    logic [31:0] mem_readdata_i = '0;
    logic        mem_waitrequest_i = 1'b0;
    logic        mem_readdatavalid_i = 1'b0;
    logic [3:0]  avm_address_o;
    logic [31:0] avm_writedata_o;
    logic        avm_write_o;
    logic        avm_read_o;
    logic [31:0] avm_readdata_i = '0;
    logic        avm_waitrequest_i = 1'b0;
    logic        done_o;
    logic        result_o;
    logic        error_o;
    logic        busy_o;

    haar_window_feeder #(
        .WINDOW_SIZE(WS), .POLL_DELAY(PD), .POLL_TIMEOUT(PT),
        .FLAG_READY_BIT(31), .FLAG_RESULT_BIT(30), .FLAG_NEW_COL_BIT(0),
        .FLAGS_ADDR(A_FLAG), .VAR_ADDR(A_VAR), .II_ADDR(A_II)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_base_addr_i(cmd_base_addr_i), .cmd_new_col_i(cmd_new_col_i),
        .cmd_var_factor_i(cmd_var_factor_i),
        .mem_address_o(mem_address_o), .mem_read_o(mem_read_o),
        .mem_readdata_i(mem_readdata_i), .mem_waitrequest_i(mem_waitrequest_i),
        .mem_readdatavalid_i(mem_readdatavalid_i),
        .avm_address_o(avm_address_o), .avm_writedata_o(avm_writedata_o),
        .avm_write_o(avm_write_o), .avm_read_o(avm_read_o),
        .avm_readdata_i(avm_readdata_i), .avm_waitrequest_i(avm_waitrequest_i),
        .done_o(done_o), .result_o(result_o), .error_o(error_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
    typedef struct { int ready_after; logic res; logic e_res; logic e_err; int e_polls; } cmp_t;
    wr_t  wq[$];
    cmp_t cq[$];

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -10, acc_cnt = 0, ii_cnt = 0;
    int polls = 0, last_ii_cyc = 0;
    bit bp = 0, stray_en = 0, gap_chk = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {24'h0, mem_read_o, avm_write_o, avm_read_o, done_o,
                            result_o, error_o, busy_o, cmd_ready_o}, 32'h1);
        chk({tag, "_mem_addr"}, mem_address_o, 32'h0);
        chk({tag, "_avm_addr"}, {28'h0, avm_address_o}, 32'h0);
        chk({tag, "_avm_data"}, avm_writedata_o, 32'h0);
    endtask

    task automatic push_cmd(input logic [31:0] base, input logic nc, input logic [31:0] vf,
                            input int ready_after, input logic res);
        int n;
        n = nc ? WS * WS : WS;
        wq.push_back('{A_VAR, vf});
        wq.push_back('{A_FLAG, {31'h0, nc}});
        for (int i = 0; i < n; i++) wq.push_back('{A_II, mem_word(base + 32'(4 * i))});
        cq.push_back('{ready_after, res, (ready_after != 0) ? res : 1'b0,
                       ready_after == 0, (ready_after != 0) ? ready_after : PT});
    endtask

    task automatic issue(input logic [31:0] base, input logic nc, input logic [31:0] vf,
                         input int ready_after, input logic res);
        bit got;
        got = 0;
        push_cmd(base, nc, vf, ready_after, res);
        @(posedge clk); #1;
        ii_cnt = 0;
        cmd_valid_i = 1'b1; cmd_base_addr_i = base; cmd_new_col_i = nc; cmd_var_factor_i = vf;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready_o) begin got = 1; break; end
        end
        chk("cmd_accept", {31'h0, got}, 32'h1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            if (done_cnt > d0) break;
        end
        chk({tag, "_done_seen"}, {31'h0, done_cnt > d0}, 32'h1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave/memory responders and the scoreboard monitor, all acting on negedge.
    initial begin : monitor
        bit p_avm_stall, p_mem_stall, p_wr, p_rd, mem_pend, ready;
        logic [3:0]  p_aaddr;
        logic [31:0] p_adata, p_maddr, mem_addr_q;
        int mem_cnt;
        wr_t  w;
        cmp_t c;
        p_avm_stall = 0; p_mem_stall = 0; mem_pend = 0; mem_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                p_avm_stall = 0; p_mem_stall = 0; mem_pend = 0; polls = 0;
                mem_readdatavalid_i = 1'b0;
            end else begin
                if (p_avm_stall) begin
                    chk("avm_hold_ctl", {26'h0, avm_write_o, avm_read_o, avm_address_o},
                        {26'h0, p_wr, p_rd, p_aaddr});
                    if (p_wr) chk("avm_hold_data", avm_writedata_o, p_adata);
                end
                if (p_mem_stall) begin
                    chk("mem_hold_rd", {31'h0, mem_read_o}, 32'h1);
                    chk("mem_hold_addr", mem_address_o, p_maddr);
                end
                if (avm_write_o || avm_read_o)
                    chk("no_wr_rd_overlap", {31'h0, avm_write_o && avm_read_o}, 32'h0);

                avm_waitrequest_i = bp ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_waitrequest_i = bp ? 1'($urandom_range(0, 1)) : 1'b0;

                mem_readdatavalid_i = 1'b0;
                if (mem_pend) begin
                    if (mem_cnt == 0) begin
                        mem_readdatavalid_i = 1'b1;
                        mem_readdata_i = mem_word(mem_addr_q);
                        mem_pend = 0;
                    end else mem_cnt--;
                end else if (stray_en && $urandom_range(0, 3) == 0) begin
                    mem_readdatavalid_i = 1'b1;
                    mem_readdata_i = 32'hDEAD_BEEF;
                end
                if (mem_read_o && !mem_waitrequest_i) begin
                    mem_pend = 1; mem_addr_q = mem_address_o;
                    mem_cnt = bp ? int'($urandom_range(0, 3)) : 0;
                end

                if (avm_write_o && !avm_waitrequest_i) begin
                    if (wq.size() == 0) chk("unexpected_write", {28'h0, avm_address_o}, 32'hFFFF);
                    else begin
                        w = wq.pop_front();
                        chk("wr_addr", {28'h0, avm_address_o}, {28'h0, w.a});
                        chk("wr_data", avm_writedata_o, w.d);
                    end
                    if (avm_address_o == A_II) begin ii_cnt++; last_ii_cyc = cyc; end
                end

                if (avm_read_o && !avm_waitrequest_i) begin
                    if (polls == 0) chk("poll_delay", {31'h0, (cyc - last_ii_cyc) >= PD + 1}, 32'h1);
                    chk("poll_addr", {28'h0, avm_address_o}, {28'h0, A_FLAG});
                    polls++;
                    ready = (cq.size() != 0) && (cq[0].ready_after != 0) && (polls >= cq[0].ready_after);
                    avm_readdata_i = ready ? {1'b1, cq[0].res, 30'h0} : 32'h7FFF_FFFE;
                end

                if (done_o) begin
                    if (cq.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
                    else begin
                        c = cq.pop_front();
                        chk("result", {31'h0, result_o}, {31'h0, c.e_res});
                        chk("error", {31'h0, error_o}, {31'h0, c.e_err});
                        chk("poll_count", polls, c.e_polls);
                    end
                    polls = 0; done_cnt++; done_cyc = cyc;
                end

                if (cmd_valid_i && cmd_ready_o) begin
                    acc_cnt++;
                    if (gap_chk) chk("accept_after_done", cyc - done_cyc, 1);
                end

                p_avm_stall = (avm_write_o || avm_read_o) && avm_waitrequest_i;
                p_wr = avm_write_o; p_rd = avm_read_o; p_aaddr = avm_address_o; p_adata = avm_writedata_o;
                p_mem_stall = mem_read_o && mem_waitrequest_i;
                p_maddr = mem_address_o;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int a0;
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_i = 1'b1;

        // Full load, zero wait
        issue(32'h0000_1000, 1'b1, 32'h0001_2345, 5, 1'b1);
        wait_done("full");
        // Shift load across the 2^32 address wrap
        issue(32'hFFFF_FFE0, 1'b0, 32'hCAFE_0001, 1, 1'b0);
        wait_done("shift_wrap");

        // Backpressure on both masters with variable memory latency
        bp = 1;
        issue(32'h0000_1000, 1'b1, 32'h0001_2345, 3, 1'b1);
        wait_done("bp_full");
        stray_en = 1;
        issue(32'h0000_8000, 1'b0, 32'h0BAD_F00D, 2, 1'b0);
        wait_done("bp_shift");
        stray_en = 0; bp = 0;

        // Timeout
        issue(32'h0000_2000, 1'b0, 32'h0000_0077, 0, 1'b0);
        wait_done("timeout");

        // Busy rejection: valid held through command A, B taken the cycle after DONE
        push_cmd(32'h0000_3000, 1'b0, 32'h0000_0011, 0, 1'b0);
        push_cmd(32'h0000_4000, 1'b0, 32'h0000_0022, 2, 1'b1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_base_addr_i = 32'h0000_3000; cmd_new_col_i = 1'b0;
        cmd_var_factor_i = 32'h0000_0011;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready_o) break;
        end
        @(posedge clk); #1;
        cmd_base_addr_i = 32'h0000_4000; cmd_var_factor_i = 32'h0000_0022;
        a0 = acc_cnt;
        wait_done("busy_a");
        gap_chk = 1;
        chk("busy_no_capture", acc_cnt, a0);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (acc_cnt > a0) break;
        end
        #1;
        cmd_valid_i = 1'b0; gap_chk = 0;
        chk("busy_b_accepted", acc_cnt, a0 + 1);
        @(negedge clk);
        chk("clear_on_accept", {30'h0, error_o, result_o}, 32'h0);
        wait_done("busy_b");

        // Reset after the 100th II write
        issue(32'h0000_5000, 1'b1, 32'h0000_0055, 3, 1'b1);
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            if (ii_cnt >= 100) break;
        end
        chk("ii_reach_100", {31'h0, ii_cnt >= 100}, 32'h1);
        #3;
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("reset_mid");
        wq.delete();
        cq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        issue(32'h0000_6000, 1'b0, 32'h0000_0066, 1, 1'b1);
        wait_done("after_reset");

        repeat (3) @(posedge clk);
        chk("wq_empty", wq.size(), 0);
        chk("cq_empty", cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
